// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit, sampled at
// OVERSAMPLE x baud, with a first-word-fall-through receive FIFO and RTS flow control.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int RTS_MARGIN = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_tick,
  input  logic       rx,
  input  logic       rx_enable,
  output logic       rx_rts_n,
  input  logic       flush,
  output logic [7:0] rxdata,
  output logic       rxdata_valid,
  input  logic       rxdata_ready,
  output logic       rxfifo_full,
  output logic       rxfifo_empty,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  logic          rx_m_q, rx_s_q;
  state_t        state_q;
  logic [TW-1:0] tcnt_q;
  logic [2:0]    bcnt_q;
  logic [7:0]    shreg_q;
  logic          perr_q;
  logic          parity_err_q, frame_err_q, overrun_err_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q, rptr_nx;
  logic [CW-1:0] count_q, count_d, remain;
  logic [7:0]    rxdata_q;
  logic          rts_q;

  logic at_last, push, pop, push_ok, overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      rx_m_q <= rx;
      rx_s_q <= rx_m_q;
    end
  end

  // A good byte is pushed in the very cycle its stop bit is sampled.
  assign at_last = sample_tick && (tcnt_q == LAST);
  assign push    = rx_enable && !flush && (state_q == STOP) && at_last && rx_s_q && !perr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tcnt_q       <= '0;
      bcnt_q       <= '0;
      shreg_q      <= '0;
      perr_q       <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (flush || !rx_enable) begin
        state_q <= IDLE;
        tcnt_q  <= '0;
      end else if (sample_tick) begin
        case (state_q)
          IDLE: if (!rx_s_q) begin
            state_q <= START;
            tcnt_q  <= '0;
          end
          START: if (tcnt_q == MID) begin
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            state_q <= rx_s_q ? IDLE : DATA;
          end else tcnt_q <= tcnt_q + 1'b1;
          DATA: if (tcnt_q == LAST) begin
            tcnt_q  <= '0;
            shreg_q <= {rx_s_q, shreg_q[7:1]};
            bcnt_q  <= bcnt_q + 1'b1;
            if (bcnt_q == 3'd7) state_q <= PARITY;
          end else tcnt_q <= tcnt_q + 1'b1;
          PARITY: if (tcnt_q == LAST) begin
            tcnt_q  <= '0;
            perr_q  <= rx_s_q ^ (^shreg_q);
            state_q <= STOP;
          end else tcnt_q <= tcnt_q + 1'b1;
          // Leaving at mid-stop so the next start edge is not missed.
          STOP: if (tcnt_q == LAST) begin
            tcnt_q <= '0;
            if (!rx_s_q) begin
              frame_err_q <= 1'b1;
              state_q     <= BREAK;
            end else begin
              parity_err_q <= perr_q;
              state_q      <= IDLE;
            end
          end else tcnt_q <= tcnt_q + 1'b1;
          BREAK: if (rx_s_q) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign pop     = (count_q != '0) && rxdata_ready;
  assign push_ok = push && ((count_q < CW'(FIFO_DEPTH)) || pop);
  assign overrun = push && !push_ok;
  assign remain  = count_q - CW'(pop);
  assign rptr_nx = rptr_q + 1'b1;

  always_comb begin
    count_d = count_q;
    if (flush) count_d = '0;
    else       count_d = count_q + CW'(push_ok) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= shreg_q;
  end

  // The head register is refilled from the incoming byte when the FIFO would
  // otherwise be empty, else from the entry behind the one being popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      rxdata_q      <= '0;
      rts_q         <= 1'b1;
      overrun_err_q <= 1'b0;
    end else begin
      count_q       <= count_d;
      rts_q         <= (CW'(FIFO_DEPTH) - count_d) <= CW'(RTS_MARGIN);
      overrun_err_q <= overrun;
      if (flush) begin
        wptr_q   <= '0;
        rptr_q   <= '0;
        rxdata_q <= '0;
      end else begin
        if (push_ok) wptr_q <= wptr_q + 1'b1;
        if (pop)     rptr_q <= rptr_nx;
        if (push_ok && remain == '0)  rxdata_q <= shreg_q;
        else if (pop && remain != '0) rxdata_q <= mem_q[rptr_nx];
      end
    end
  end

  assign rxdata       = rxdata_q;
  assign rxdata_valid = (count_q != '0);
  assign rxfifo_empty = (count_q == '0);
  assign rxfifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign rx_rts_n     = rts_q;
  assign parity_err   = parity_err_q;
  assign frame_err    = frame_err_q;
  assign overrun_err  = overrun_err_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver. Deserialises the frame produced by the team's transmitter: start bit (0), 8 data bits LSB first, even parity bit (XOR of data bits), 1 stop bit (1).
- Samples the asynchronous rx line at OVERSAMPLE x baud and buffers good bytes in an internal first-word-fall-through FIFO.
- Drives rx_rts_n for hardware flow control and pulses per-frame error flags toward the IRQ logic.

Parameters:
- OVERSAMPLE, 16, sample_tick pulses per bit period; even, >= 4.
- FIFO_DEPTH, 8, RX FIFO entries; power of two, >= 4.
- RTS_MARGIN, 2, rx_rts_n deasserts when free entries <= RTS_MARGIN.

Ports:
- clk  in  1  system clock; the single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- sample_tick  in  1  one-cycle enable at OVERSAMPLE x baud.
- rx  in  1  serial input; asynchronous, idle high.
- rx_enable  in  1  receiver enable.
- rx_rts_n  out  1  request-to-send, active low: the FIFO has room.
- flush  in  1  synchronous clear of the FIFO and the frame in progress.
- rxdata  out  8  FIFO head byte.
- rxdata_valid  out  1  FIFO not empty.
- rxdata_ready  in  1  pop the head.
- rxfifo_full  out  1  FIFO full.
- rxfifo_empty  out  1  FIFO empty.
- parity_err  out  1  one-cycle pulse: parity mismatch.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- overrun_err  out  1  one-cycle pulse: good byte dropped because the FIFO is full.

Behaviour:
- Reset values: rxdata_valid=0, rxfifo_empty=1, rxfifo_full=0, rx_rts_n=1, all error pulses 0, rxdata=0, state=IDLE.
- Synchroniser registers reset to 1. First cycle after reset, rx_rts_n=0.
- rx passes through a 2-flop synchroniser (rx_s). All FSM and counter activity advances only on cycles with sample_tick=1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: rx_s==0 on a tick -> START, tick counter=0.
- START: at tick count OVERSAMPLE/2-1 (mid-bit), sample rx_s.
  - rx_s==1 -> false start, back to IDLE, no flags.
  - rx_s==0 -> DATA, counter=0.
- DATA: sample every OVERSAMPLE ticks. Shift into shreg[7:0] LSB first. Bit counter 0..7; after bit 7 -> PARITY.
- PARITY: sample one bit period later. perr = sample XOR (^shreg). -> STOP.
- STOP: sample one bit period later.
  - Stop==0 -> frame_err pulse, byte discarded, -> BREAK.
  - Stop==1 and perr -> parity_err pulse, byte discarded, -> IDLE.
  - Otherwise push shreg and -> IDLE.
  - The pulse/push happens in the same clk cycle as the stop sample. IDLE is re-entered at mid-stop so the next start edge is seen.
- BREAK: wait until rx_s==1 on a tick, then -> IDLE. Holding the line low never produces repeated frame_err.
- Error precedence: only one error pulse per frame, priority frame_err > parity_err > overrun_err.
- FIFO storage:
  - Push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle (count unchanged).
  - Otherwise the byte is dropped and overrun_err pulses.
  - Pop when rxdata_valid && rxdata_ready. Pop while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH. count width is clog2(FIFO_DEPTH)+1.
- FIFO outputs:
  - rxdata is registered at the head and is valid the cycle after a push into an empty FIFO (latency: stop sample -> rxdata_valid = 1 clk).
  - rxdata is held stable while rxdata_valid && !rxdata_ready.
- rx_rts_n is registered: 1 when (FIFO_DEPTH - count) <= RTS_MARGIN, else 0.
- flush (priority over everything except reset):
  - Next cycle count=0, pointers=0, rxdata_valid=0.
  - FSM -> IDLE; a push that would occur in the flush cycle is dropped silently (no overrun_err).
- rx_enable=0: FSM held in IDLE and any partial frame is aborted without flags. The FIFO stays readable.
- Reset mid-frame: everything returns to reset values immediately (asynchronous). The partial frame is lost.

Test Plan:
- OVERSAMPLE=16, sample_tick=1 every cycle, send frame for 0xA5 (parity 0, stop 1) -> rxdata=0xA5, rxdata_valid=1 one cycle after mid-stop, no error pulses.
- Send 0x01 with parity bit 0 (should be 1) -> single parity_err pulse, FIFO stays empty. Then send 0x3C correctly -> rxdata=0x3C.
- Send 0x55 with stop bit 0, hold rx low 40 bit periods -> exactly one frame_err, no push, state BREAK until rx high. Next frame 0x0F received OK.
- Glitch rx low for 4 ticks, then high -> no push, no flags, FSM back in IDLE.
- FIFO_DEPTH=8, send 8 bytes 0x10..0x17 with rxdata_ready=0 -> rx_rts_n=1 after 6th push, rxfifo_full=1 after 8th. Send 0x18 -> overrun_err pulse. Drain -> 0x10..0x17 in order, rx_rts_n back to 0.
- With 3 bytes queued, assert flush during the DATA state of a 4th frame -> rxfifo_empty=1 next cycle, no push, no flags. Following frame 0x99 received. Assert rst_n=0 mid-frame -> all outputs at reset values.
